// File: rtl/fifo_wr_arb_ctrl.sv
// Write-side arbiter and pointer/occupancy controller for a single-clock FIFO.
// Round-robin grants requesters onto the write port and sequences a drain mode.
module fifo_wr_arb_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int RAM_DEPTH  = 64,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rd_req,
  output logic                          rd_ack,
  output logic                          rd_valid,
  input  logic                          drain,
  output logic                          drain_done,
  output logic                          fifo_wr_cs,
  output logic                          fifo_wr_en,
  output logic [ADDR_WIDTH-1:0]         fifo_addr_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_rd_cs,
  output logic                          fifo_rd_en,
  output logic [ADDR_WIDTH-1:0]         fifo_addr_rd,
  output logic [ADDR_WIDTH:0]           count,
  output logic                          full,
  output logic                          empty
);

  localparam int RR_W = $clog2(NUM_REQ);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                state;
  logic [RR_W-1:0]       rr_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [RD_LAT-1:0]     rd_vld_p;
  logic [RR_W-1:0]       gnt_idx;
  logic                  wr_hs;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic [RR_W:0]         scan_idx;

  assign full     = (count == (ADDR_WIDTH+1)'(RAM_DEPTH));
  assign empty    = (count == '0);
  assign rd_ack   = !rst && rd_req && !empty;
  assign rd_valid = rd_vld_p[RD_LAT-1];

  // Grant goes to the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    req_ready = '0;
    gnt_idx   = '0;
    wr_hs     = 1'b0;
    scan_idx  = '0;
    if (!rst && state == RUN && !full) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        scan_idx = {1'b0, rr_ptr} + (RR_W+1)'(i);
        if (scan_idx >= (RR_W+1)'(NUM_REQ))
          scan_idx = scan_idx - (RR_W+1)'(NUM_REQ);
        if (!wr_hs && req_valid[scan_idx[RR_W-1:0]]) begin
          wr_hs                           = 1'b1;
          gnt_idx                         = scan_idx[RR_W-1:0];
          req_ready[scan_idx[RR_W-1:0]]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (wr_hs && !rd_ack)
      count_nxt = count + 1'b1;
    else if (!wr_hs && rd_ack)
      count_nxt = count - 1'b1;
  end

  // Stage p0 -> registered FIFO strobes, pointers, occupancy and drain FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      rr_ptr       <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      fifo_wr_cs   <= 1'b0;
      fifo_wr_en   <= 1'b0;
      fifo_addr_wr <= '0;
      fifo_data_in <= '0;
      fifo_rd_cs   <= 1'b0;
      fifo_rd_en   <= 1'b0;
      fifo_addr_rd <= '0;
      rd_vld_p     <= '0;
      drain_done   <= 1'b0;
    end else begin
      fifo_wr_cs <= wr_hs;
      fifo_wr_en <= wr_hs;
      if (wr_hs) begin
        fifo_addr_wr <= wr_ptr;
        fifo_data_in <= req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr       <= wr_ptr + 1'b1;
        rr_ptr       <= (gnt_idx == RR_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
      end

      fifo_rd_cs <= rd_ack;
      fifo_rd_en <= rd_ack;
      if (rd_ack) begin
        fifo_addr_rd <= rd_ptr;
        rd_ptr       <= rd_ptr + 1'b1;
      end

      rd_vld_p[0] <= rd_ack;
      for (int i = 1; i < RD_LAT; i++)
        rd_vld_p[i] <= rd_vld_p[i-1];

      count      <= count_nxt;
      drain_done <= 1'b0;

      unique case (state)
        RUN: begin
          if (drain)
            state <= DRAIN;
        end
        DRAIN: begin
          if (count_nxt == '0) begin
            state      <= RUN;
            drain_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// Randomized bench for fifo_wr_arb_ctrl against a queue-based FIFO/arbiter model.
module tb_fifo_wr_arb_ctrl;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int RL    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rd_req, rd_ack, rd_valid;
  logic            drain, drain_done;
  logic            fifo_wr_cs, fifo_wr_en, fifo_rd_cs, fifo_rd_en;
  logic [AW-1:0]   fifo_addr_wr, fifo_addr_rd;
  logic [DW-1:0]   fifo_data_in;
  logic [AW:0]     count;
  logic            full, empty;

  always #5 clk = ~clk;

  fifo_wr_arb_ctrl #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .drain(drain), .drain_done(drain_done),
    .fifo_wr_cs(fifo_wr_cs), .fifo_wr_en(fifo_wr_en), .fifo_addr_wr(fifo_addr_wr),
    .fifo_data_in(fifo_data_in), .fifo_rd_cs(fifo_rd_cs), .fifo_rd_en(fifo_rd_en),
    .fifo_addr_rd(fifo_addr_rd), .count(count), .full(full), .empty(empty)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, pointers as plain modulo counters.
  logic [DW-1:0] q[$];
  int            m_wr = 0, m_rd = 0, m_rr = 0;
  bit            m_drain = 0;
  bit            e_wr_en = 0, e_rd_en = 0, e_dd = 0;
  int            e_awr = 0, e_ard = 0;
  logic [DW-1:0] e_din = '0, e_rdata = '0;
  bit            hist[RL];
  logic [DW-1:0] mem[DEPTH];

  function automatic int model_grant(input logic [N-1:0] v, input bit rs);
    if (rs || m_drain || q.size() >= DEPTH) return -1;
    for (int k = 0; k < N; k++)
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic step(input logic [N-1:0] v, input bit rq, input bit dr, input bit rs);
    int           g;
    bit           ack;
    logic [N-1:0] exp_rdy;
    req_valid = v;
    rd_req    = rq;
    drain     = dr;
    rst       = rs;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    g   = model_grant(v, rs);
    ack = !rs && rq && (q.size() > 0);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;

    @(negedge clk);
    chk("req_ready", req_ready, exp_rdy);
    chk("rd_ack", rd_ack, ack);
    chk("count", count, q.size());
    chk("full", full, q.size() == DEPTH);
    chk("empty", empty, q.size() == 0);
    chk("wr_en", {fifo_wr_en, fifo_wr_cs}, {e_wr_en, e_wr_en});
    chk("addr_wr", fifo_addr_wr, e_awr);
    chk("data_in", fifo_data_in, e_din);
    chk("rd_en", {fifo_rd_en, fifo_rd_cs}, {e_rd_en, e_rd_en});
    chk("addr_rd", fifo_addr_rd, e_ard);
    chk("rd_valid", rd_valid, hist[RL-1]);
    chk("drain_done", drain_done, e_dd);
    if (fifo_wr_en === 1'b1) mem[fifo_addr_wr] = fifo_data_in;
    if (e_rd_en) chk("rd_order", mem[fifo_addr_rd], e_rdata);

    @(posedge clk);
    if (rs) begin
      q.delete();
      m_wr = 0; m_rd = 0; m_rr = 0; m_drain = 0;
      e_wr_en = 0; e_rd_en = 0; e_dd = 0; e_awr = 0; e_ard = 0; e_din = '0;
      for (int k = 0; k < RL; k++) hist[k] = 0;
    end else begin
      e_rd_en = ack;
      if (ack) begin
        e_ard   = m_rd;
        e_rdata = q.pop_front();
        m_rd    = (m_rd + 1) % DEPTH;
      end
      e_wr_en = (g >= 0);
      if (g >= 0) begin
        e_awr = m_wr;
        e_din = req_data[g*DW +: DW];
        q.push_back(e_din);
        m_wr  = (m_wr + 1) % DEPTH;
        m_rr  = (g + 1) % N;
      end
      for (int k = RL-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = ack;
      e_dd = 0;
      if (m_drain) begin
        if (q.size() == 0) begin
          m_drain = 0;
          e_dd    = 1;
        end
      end else if (dr) begin
        m_drain = 1;
      end
    end
    #1;
  endtask

  int fair_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  int fair_b[6] = '{1, 3, 1, 3, 1, 3};
  int budget;

  initial begin
    for (int k = 0; k < RL; k++) hist[k] = 0;
    rst = 1'b1; req_valid = '1; rd_req = 1'b0; drain = 1'b0; req_data = '0;
    @(posedge clk); #1;
    repeat (2) step('1, 0, 0, 1);

    // Fill from requester 0 only; the extra requests must be refused.
    repeat (66) step(4'b0001, 0, 0, 0);
    chk("fill_count", count, 64);
    chk("fill_full", full, 1);
    chk("fill_last_addr", fifo_addr_wr, 63);

    // Restart, preload 10 words from requester 3 so the RR pointer sits at 0.
    step('0, 0, 0, 1);
    repeat (10) step(4'b1000, 0, 0, 0);
    req_valid = '1; rd_req = 1'b0; drain = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      chk("fair_1111", req_ready, N'(1) << fair_a[k]);
      step('1, 0, 0, 0);
    end
    req_valid = 4'b1010; #1;
    for (int k = 0; k < 6; k++) begin
      chk("fair_1010", req_ready, N'(1) << fair_b[k]);
      step(4'b1010, 0, 0, 0);
    end

    repeat (14) step('0, 1, 0, 0);
    chk("pre_sim_count", count, 10);
    step(4'b0100, 1, 0, 0);
    chk("sim_count", count, 10);
    chk("sim_addr_wr", fifo_addr_wr, 24);
    chk("sim_addr_rd", fifo_addr_rd, 14);
    chk("sim_strobes", {fifo_wr_en, fifo_rd_en}, 2'b11);

    // Wrap: interleaved writes and reads run both pointers past 63.
    for (int k = 0; k < 140; k++) begin
      if (k % 2 == 0) step(N'($urandom_range(1, 15)), 0, 0, 0);
      else step('0, 1, 0, 0);
    end

    for (int k = 0; k < 600; k++)
      step(N'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, 0);

    // Drain with requesters active.
    step('0, 0, 0, 1);
    repeat (5) step(4'b0001, 0, 0, 0);
    step('1, 0, 1, 0);
    chk("drain_block", req_ready, 0);
    for (budget = 0; budget < 100 && m_drain; budget++) step('1, 1, 0, 0);
    chk("drain_exit", drain_done, 1);
    step('1, 0, 0, 0);
    chk("drain_resume", fifo_wr_en, 1);
    chk("drain_pulse_once", drain_done, 0);

    // Drain while already empty.
    for (budget = 0; budget < 100 && q.size() > 0; budget++) step('0, 1, 0, 0);
    chk("empty_before_drain", empty, 1);
    step('0, 0, 1, 0);
    step('0, 0, 0, 0);
    chk("empty_drain_done", drain_done, 1);
    step('0, 0, 0, 0);

    // Reset in the middle of a drain.
    repeat (8) step(4'b0010, 0, 0, 0);
    step('0, 0, 1, 0);
    repeat (2) step('0, 1, 0, 0);
    step('0, 1, 0, 1);
    chk("rst_mid_count", count, 0);
    repeat (4) step('0, 0, 0, 0);
    step(4'b0100, 0, 0, 0);
    chk("rst_mid_run", fifo_wr_en, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
